bf_exmem_pipe: RTL and testbench
================================

# bf_exmem_pipe

Parametrised EX/MEM pipeline register for the MIPS datapath, successor to the fixed single-stage EX/MEM buffer. It carries the branch-target adder result, zero flag, ALU result, jump-target concatenation, store data, destination register and the M/WB control bundles from EX to MEM. It adds a per-entry valid bit, global stall (hold), flush (bubble insertion), configurable depth 1..4 and control squashing for invalid entries.

## Interface
- ADDR_W, 8, width of branch-target adder result
- DATA_W, 32, width of ALU result, jump target and store data
- REG_W, 5, destination register index width
- DEPTH, 1, number of register stages (legal 1..4)

- clk_BFX  in  1  clock, all state on rising edge
- rstn_BFX  in  1  reset; synchronous, active-low
- stall_BFX  in  1  hold all stages
- flush_BFX  in  1  kill all in-flight entries
- valid_BFX_IN  in  1  EX result valid
- resAdd1_BFX_IN  in  ADDR_W  branch target
- zf_BFX_IN  in  1  ALU zero flag
- resALU_BFX_IN  in  DATA_W  ALU result / memory address
- concatenador_BFX_IN  in  DATA_W  jump target
- regData2_BFX_IN  in  DATA_W  store data
- mux2Output_BFX_IN  in  REG_W  destination register
- M_BFX_IN  in  4  {branch, MemRead, MemWrite, jump}, bit 3 = branch
- WB_BFX_IN  in  2  writeback control
- valid_BFX  out  1  output entry valid
- resAdd1_BFX, zf_BFX, resALU_BFX, concatenador_BFX, regData2_BFX, mux2Output_BFX  out  matching widths  registered data
- WB_BFX  out  2  registered WB bundle
- branch_BFX, MemRead_BFX, MemWrite_BFX, jump_BFX  out  1 each  M[3], M[2], M[1], M[0]
- stall_cnt_BFX  out  16  stall counter (only with BFX_STALL_CNT_EN)

## Operation
- Stage 0 captures inputs; stage k captures stage k-1; outputs are driven directly from stage DEPTH-1.
- Capture masking: when valid_BFX_IN=0, stage 0 stores M=0 and WB=0 (data fields still captured). An invalid entry therefore never asserts MemWrite, MemRead, branch, jump or register write.
- Priority, per edge: reset > flush > stall > advance.
- Reset (rstn_BFX=0 at edge): every stage clears all fields to 0; all outputs read 0; stall_cnt_BFX=0.
- Flush: every stage clears valid, M and WB; data fields keep their values; inputs on that edge are discarded. Flush takes precedence over simultaneous stall.
- Stall (without flush): every stage holds; inputs are discarded. The upstream stage is responsible for holding EX.
- Advance: all stages shift by one.
- No state machine. Each stage is a data register plus valid, under the three-way reset/flush/stall priority.

## Timing
- Latency DEPTH cycles from input to output when no stall occurs; throughput one entry per cycle.
- Each stall cycle adds exactly one cycle of latency to every in-flight entry.
- Outputs change only on the rising clk_BFX edge; there is no combinational input-to-output path.
- Reset asserted mid-stream clears in-flight entries on that same edge; the first post-reset capture happens on the first edge with rstn_BFX=1.
- Flush and valid input on the same edge: the input is dropped and valid_BFX reads 0 on the following cycle(s).

## Configuration
- BFX_STALL_CNT_EN defined: adds stall_cnt_BFX.
  - Increments on each edge where stall_BFX=1, flush_BFX=0 and rstn_BFX=1.
  - Saturates at 16'hFFFF; cleared only by reset.
- BFX_STALL_CNT_EN undefined: no port and no counter logic; all other behaviour is identical.

## Structure
- Package bf_pkg contains:
  - M bit index constants: M_BRANCH=3, M_MEMREAD=2, M_MEMWRITE=1, M_JUMP=0.
  - WB_W=2.
  - A parametrised stage-record typedef with fields valid, resAdd1, zf, resALU, concatenador, regData2, mux2Output, M, WB.
- One sub-module, bf_stage: a single register stage with clk, rstn, stall, flush, d and q record. It is instantiated DEPTH times in a generate loop. The top level adds the capture masking and the optional counter.

## Test plan
- Reset: drive nonzero inputs, hold rstn_BFX=0 for 2 cycles -> all outputs 0, valid_BFX=0.
- DEPTH=1, valid=1, resALU=32'h0000_0040, M=4'b0010, WB=2'b01 -> next cycle resALU_BFX=32'h40, MemWrite_BFX=1, WB_BFX=2'b01, valid_BFX=1.
- Invalid masking: valid_BFX_IN=0 with M=4'b1111 and WB=2'b11 -> branch/MemRead/MemWrite/jump=0, WB_BFX=0, valid_BFX=0.
- DEPTH=3 stream of entries A,B,C with stall on the cycle after B enters -> A appears at cycle 4 (not 3); order A,B,C is preserved with no duplicates.
- Flush together with stall while 2 valid entries are in flight (DEPTH=2) -> the next outputs have valid=0, M=0, WB=0; regData2_BFX retains its previous value.
- With BFX_STALL_CNT_EN: 70000 stall cycles -> stall_cnt_BFX=16'hFFFF; reset -> 0.

Source files
------------

// File: rtl/bf_pkg.sv
// bf_pkg: shared constants and the stage record for the EX/MEM pipeline.
// M bundle bit positions, WB width and the default-width stage record used
// by bf_stage when no record type is supplied.
package bf_pkg;

   localparam int M_W        = 4;
   localparam int WB_W       = 2;

   localparam int M_BRANCH   = 3;
   localparam int M_MEMREAD  = 2;
   localparam int M_MEMWRITE = 1;
   localparam int M_JUMP     = 0;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;
   localparam int REG_W_DEF  = 5;

   // Stage record at the default widths. The top level declares the same
   // field layout at its own parameter widths and hands that type to bf_stage.
   typedef struct packed {
      logic                  valid;
      logic [ADDR_W_DEF-1:0] resAdd1;
      logic                  zf;
      logic [DATA_W_DEF-1:0] resALU;
      logic [DATA_W_DEF-1:0] concatenador;
      logic [DATA_W_DEF-1:0] regData2;
      logic [REG_W_DEF-1:0]  mux2Output;
      logic [M_W-1:0]        M;
      logic [WB_W-1:0]       WB;
   } bf_rec_t;

endpackage

// File: rtl/bf_exmem_pipe_if.sv
// bf_exmem_pipe_if: EX-side inputs, pipeline controls and MEM-side outputs
// of the EX/MEM register. master = EX/control side, slave = the pipeline.
interface bf_exmem_pipe_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   import bf_pkg::*;

   logic              stall_BFX;
   logic              flush_BFX;

   logic              valid_BFX_IN;
   logic [ADDR_W-1:0] resAdd1_BFX_IN;
   logic              zf_BFX_IN;
   logic [DATA_W-1:0] resALU_BFX_IN;
   logic [DATA_W-1:0] concatenador_BFX_IN;
   logic [DATA_W-1:0] regData2_BFX_IN;
   logic [REG_W-1:0]  mux2Output_BFX_IN;
   logic [M_W-1:0]    M_BFX_IN;
   logic [WB_W-1:0]   WB_BFX_IN;

   logic              valid_BFX;
   logic [ADDR_W-1:0] resAdd1_BFX;
   logic              zf_BFX;
   logic [DATA_W-1:0] resALU_BFX;
   logic [DATA_W-1:0] concatenador_BFX;
   logic [DATA_W-1:0] regData2_BFX;
   logic [REG_W-1:0]  mux2Output_BFX;
   logic [WB_W-1:0]   WB_BFX;
   logic              branch_BFX;
   logic              MemRead_BFX;
   logic              MemWrite_BFX;
   logic              jump_BFX;

   modport master (
      output stall_BFX, flush_BFX, valid_BFX_IN, resAdd1_BFX_IN, zf_BFX_IN,
             resALU_BFX_IN, concatenador_BFX_IN, regData2_BFX_IN,
             mux2Output_BFX_IN, M_BFX_IN, WB_BFX_IN,
      input  valid_BFX, resAdd1_BFX, zf_BFX, resALU_BFX, concatenador_BFX,
             regData2_BFX, mux2Output_BFX, WB_BFX, branch_BFX, MemRead_BFX,
             MemWrite_BFX, jump_BFX
   );

   modport slave (
      input  stall_BFX, flush_BFX, valid_BFX_IN, resAdd1_BFX_IN, zf_BFX_IN,
             resALU_BFX_IN, concatenador_BFX_IN, regData2_BFX_IN,
             mux2Output_BFX_IN, M_BFX_IN, WB_BFX_IN,
      output valid_BFX, resAdd1_BFX, zf_BFX, resALU_BFX, concatenador_BFX,
             regData2_BFX, mux2Output_BFX, WB_BFX, branch_BFX, MemRead_BFX,
             MemWrite_BFX, jump_BFX
   );

endinterface

// File: rtl/bf_stage.sv
// bf_stage: one EX/MEM register stage. Synchronous active-low reset clears
// everything; flush turns the entry into a bubble (valid/M/WB cleared, data
// kept); stall holds; otherwise the stage loads d.
module bf_stage #(
   parameter type rec_t = bf_pkg::bf_rec_t
) (
   input  logic clk,
   input  logic rstn,
   input  logic stall,
   input  logic flush,
   input  rec_t d,
   output rec_t q
);

   // Stage register with reset > flush > stall > load priority.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         q <= '0;
      end else if (flush) begin
         q.valid <= 1'b0;
         q.M     <= '0;
         q.WB    <= '0;
      end else if (!stall) begin
         q <= d;
      end
   end

endmodule

// File: rtl/bf_exmem_pipe.sv
// bf_exmem_pipe: parametrised EX/MEM pipeline register (DEPTH 1..4 stages).
// Stage 0 captures the EX result with the M/WB controls squashed for invalid
// entries, so a bubble can never write memory, branch, jump or write a
// register. Outputs come straight from the last stage.
// Optional feature macro: BFX_STALL_CNT_EN adds the saturating 16-bit
// stall_cnt_BFX output counting stalled (non-flushed, non-reset) edges.
module bf_exmem_pipe
   import bf_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int DEPTH  = 1
) (
   input  logic              clk_BFX,
   input  logic              rstn_BFX,
   bf_exmem_pipe_if.slave    bus
`ifdef BFX_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt_BFX
`endif
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] resAdd1;
      logic              zf;
      logic [DATA_W-1:0] resALU;
      logic [DATA_W-1:0] concatenador;
      logic [DATA_W-1:0] regData2;
      logic [REG_W-1:0]  mux2Output;
      logic [M_W-1:0]    M;
      logic [WB_W-1:0]   WB;
   } stage_rec_t;

   stage_rec_t capture;
   stage_rec_t stage_d [DEPTH];
   stage_rec_t stage_q [DEPTH];

   // Build the stage-0 record; an invalid entry keeps its data but carries
   // no memory, control-flow or writeback intent.
   always_comb begin
      capture              = '0;
      capture.valid        = bus.valid_BFX_IN;
      capture.resAdd1      = bus.resAdd1_BFX_IN;
      capture.zf           = bus.zf_BFX_IN;
      capture.resALU       = bus.resALU_BFX_IN;
      capture.concatenador = bus.concatenador_BFX_IN;
      capture.regData2     = bus.regData2_BFX_IN;
      capture.mux2Output   = bus.mux2Output_BFX_IN;
      capture.M            = bus.valid_BFX_IN ? bus.M_BFX_IN  : '0;
      capture.WB           = bus.valid_BFX_IN ? bus.WB_BFX_IN : '0;
   end

   assign stage_d[0] = capture;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi > 0) begin : g_chain
         assign stage_d[gi] = stage_q[gi-1];
      end
      bf_stage #(
         .rec_t (stage_rec_t)
      ) u_stage (
         .clk   (clk_BFX),
         .rstn  (rstn_BFX),
         .stall (bus.stall_BFX),
         .flush (bus.flush_BFX),
         .d     (stage_d[gi]),
         .q     (stage_q[gi])
      );
   end

   assign bus.valid_BFX        = stage_q[DEPTH-1].valid;
   assign bus.resAdd1_BFX      = stage_q[DEPTH-1].resAdd1;
   assign bus.zf_BFX           = stage_q[DEPTH-1].zf;
   assign bus.resALU_BFX       = stage_q[DEPTH-1].resALU;
   assign bus.concatenador_BFX = stage_q[DEPTH-1].concatenador;
   assign bus.regData2_BFX     = stage_q[DEPTH-1].regData2;
   assign bus.mux2Output_BFX   = stage_q[DEPTH-1].mux2Output;
   assign bus.WB_BFX           = stage_q[DEPTH-1].WB;
   assign bus.branch_BFX       = stage_q[DEPTH-1].M[M_BRANCH];
   assign bus.MemRead_BFX      = stage_q[DEPTH-1].M[M_MEMREAD];
   assign bus.MemWrite_BFX     = stage_q[DEPTH-1].M[M_MEMWRITE];
   assign bus.jump_BFX         = stage_q[DEPTH-1].M[M_JUMP];

`ifdef BFX_STALL_CNT_EN
   // Count edges where the pipe genuinely held; a flush overrides the stall
   // so it is not counted. The counter sticks at all-ones until reset.
   always_ff @(posedge clk_BFX) begin
      if (!rstn_BFX) begin
         stall_cnt_BFX <= '0;
      end else if (bus.stall_BFX && !bus.flush_BFX && (stall_cnt_BFX != 16'hFFFF)) begin
         stall_cnt_BFX <= stall_cnt_BFX + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bf_exmem_pipe.sv
// tb_bf_exmem_pipe: drives the same directed stream into three pipes of
// DEPTH 1, 2 and 3. Expected entries are queued per pipe at issue time and
// a monitor pops and compares whenever a pipe presents a new valid entry.
// Optional feature macro: BFX_STALL_CNT_EN enables the stall counter checks.
module tb_bf_exmem_pipe;

   typedef struct packed {
      logic        valid;
      logic [7:0]  add1;
      logic        zf;
      logic [31:0] alu;
      logic [31:0] conc;
      logic [31:0] rd2;
      logic [4:0]  dst;
      logic [3:0]  m;
      logic [1:0]  wb;
   } out_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic stall = 1'b0;
   logic flush = 1'b0;
   out_t stim = '0;
   logic advanced = 1'b0;

   out_t obs [3];
   out_t expq0 [$];
   out_t expq1 [$];
   out_t expq2 [$];

   int checksTotal = 0;
   int checksPassed = 0;

   bit   mHave;
   out_t mExp;

`ifdef BFX_STALL_CNT_EN
   logic [15:0] cnt [3];
`endif

   always #5 clk = ~clk;

   bf_exmem_pipe_if #(.ADDR_W(8), .DATA_W(32), .REG_W(5)) bus [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign bus[g].stall_BFX           = stall;
      assign bus[g].flush_BFX           = flush;
      assign bus[g].valid_BFX_IN        = stim.valid;
      assign bus[g].resAdd1_BFX_IN      = stim.add1;
      assign bus[g].zf_BFX_IN           = stim.zf;
      assign bus[g].resALU_BFX_IN       = stim.alu;
      assign bus[g].concatenador_BFX_IN = stim.conc;
      assign bus[g].regData2_BFX_IN     = stim.rd2;
      assign bus[g].mux2Output_BFX_IN   = stim.dst;
      assign bus[g].M_BFX_IN            = stim.m;
      assign bus[g].WB_BFX_IN           = stim.wb;

      assign obs[g] = '{valid: bus[g].valid_BFX, add1: bus[g].resAdd1_BFX,
                        zf: bus[g].zf_BFX, alu: bus[g].resALU_BFX,
                        conc: bus[g].concatenador_BFX, rd2: bus[g].regData2_BFX,
                        dst: bus[g].mux2Output_BFX,
                        m: {bus[g].branch_BFX, bus[g].MemRead_BFX,
                            bus[g].MemWrite_BFX, bus[g].jump_BFX},
                        wb: bus[g].WB_BFX};

      bf_exmem_pipe #(
         .ADDR_W (8),
         .DATA_W (32),
         .REG_W  (5),
         .DEPTH  (g + 1)
      ) u_dut (
         .clk_BFX  (clk),
         .rstn_BFX (rstn),
         .bus      (bus[g])
`ifdef BFX_STALL_CNT_EN
         ,
         .stall_cnt_BFX (cnt[g])
`endif
      );
   end

   // Remember whether the last edge shifted the pipes, so the monitor only
   // consumes an output entry once.
   always @(posedge clk) begin
      advanced <= rstn && !flush && !stall;
   end

   function automatic out_t killed(input out_t e);
      out_t r;
      r       = e;
      r.valid = 1'b0;
      r.m     = '0;
      r.wb    = '0;
      return r;
   endfunction

   task automatic checkOutput(input string name, input out_t got, input out_t exp);
      checksTotal++;
      if (got === exp) checksPassed++;
      else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic checkCount(input string name, input int got, input int exp);
      checksTotal++;
      if (got == exp) checksPassed++;
      else $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic popExp(input int k, output bit have, output out_t e);
      have = 1'b0;
      e    = '0;
      case (k)
         0: if (expq0.size() != 0) begin e = expq0.pop_front(); have = 1'b1; end
         1: if (expq1.size() != 0) begin e = expq1.pop_front(); have = 1'b1; end
         default: if (expq2.size() != 0) begin e = expq2.pop_front(); have = 1'b1; end
      endcase
   endtask

   // Scoreboard monitor: every freshly presented valid entry must be the
   // oldest outstanding expected entry of that pipe.
   always @(negedge clk) begin
      if (advanced) begin
         for (int k = 0; k < 3; k++) begin
            if (obs[k].valid) begin
               popExp(k, mHave, mExp);
               if (!mHave) begin
                  checksTotal++;
                  $display("[TB] FAIL sb_dut%0d_unexpected: got %h expected no entry", k + 1, obs[k]);
               end else begin
                  checkOutput($sformatf("sb_dut%0d", k + 1), obs[k], mExp);
               end
            end
         end
      end
   end

   // One edge of stimulus. emerges[k] says whether this entry is expected to
   // leave pipe k (DEPTH k+1); stalled and flushed inputs never do.
   task automatic applyStimulus(input out_t s, input logic st, input logic fl,
                                input logic [2:0] emerges);
      stim  = s;
      stall = st;
      flush = fl;
      @(posedge clk);
      if (s.valid) begin
         if (emerges[0]) expq0.push_back(s);
         if (emerges[1]) expq1.push_back(s);
         if (emerges[2]) expq2.push_back(s);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b0, 3'b000);
   endtask

   // Directed sequence.
   initial begin
      out_t t2, t3, a, b, c, junk, e1, e2;
      t2   = '{1'b1, 8'h12, 1'b0, 32'h0000_0040, 32'h0040_0100, 32'h1111_2222, 5'd3,  4'b0010, 2'b01};
      t3   = '{1'b0, 8'h34, 1'b1, 32'h0000_1234, 32'h0040_0200, 32'h3333_4444, 5'd7,  4'b1111, 2'b11};
      a    = '{1'b1, 8'hA1, 1'b1, 32'hAAAA_0001, 32'h0A00_0010, 32'hDA7A_000A, 5'd10, 4'b0100, 2'b11};
      b    = '{1'b1, 8'hB2, 1'b0, 32'hBBBB_0002, 32'h0B00_0020, 32'hDA7A_000B, 5'd11, 4'b0010, 2'b00};
      c    = '{1'b1, 8'hC3, 1'b1, 32'hCCCC_0003, 32'h0C00_0030, 32'hDA7A_000C, 5'd12, 4'b1000, 2'b10};
      junk = '{1'b1, 8'hEE, 1'b1, 32'hEEEE_EEEE, 32'hEEEE_0000, 32'hDEAD_BEEF, 5'd31, 4'b1111, 2'b11};
      e1   = '{1'b1, 8'h51, 1'b0, 32'h5555_0001, 32'h0500_0010, 32'h0000_E1E1, 5'd21, 4'b0001, 2'b01};
      e2   = '{1'b1, 8'h62, 1'b1, 32'h6666_0002, 32'h0600_0020, 32'h0000_E2E2, 5'd22, 4'b0110, 2'b10};

      // Reset held for two edges with busy inputs.
      rstn  = 1'b0;
      stim  = junk;
      stall = 1'b0;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) checkOutput($sformatf("reset_dut%0d", k + 1), obs[k], '0);
`ifdef BFX_STALL_CNT_EN
      for (int k = 0; k < 3; k++) checkCount($sformatf("reset_cnt_dut%0d", k + 1), int'(cnt[k]), 0);
`endif
      rstn = 1'b1;

      // Single store entry through the one-stage pipe.
      applyStimulus(t2, 1'b0, 1'b0, 3'b111);
      checkOutput("d1_store", obs[0], t2);

      // Invalid entry: data captured, controls squashed.
      applyStimulus(t3, 1'b0, 1'b0, 3'b000);
      checkOutput("d1_invalid_mask", obs[0], killed(t3));
      idle(3);

      // A, B, stall (input discarded), C.
      applyStimulus(a, 1'b0, 1'b0, 3'b111);
      applyStimulus(b, 1'b0, 1'b0, 3'b111);
      applyStimulus(junk, 1'b1, 1'b0, 3'b000);
      checkOutput("d3_stall_hold", obs[2], '0);
      applyStimulus(c, 1'b0, 1'b0, 3'b111);
      checkOutput("d3_A_at_cycle4", obs[2], a);
      idle(4);

      // Two entries in flight, then flush together with stall.
      applyStimulus(e1, 1'b0, 1'b0, 3'b011);
      applyStimulus(e2, 1'b0, 1'b0, 3'b001);
      applyStimulus(junk, 1'b1, 1'b1, 3'b000);
      checkOutput("d2_flush_out", obs[1], killed(e1));
      checkOutput("d1_flush_out", obs[0], killed(e2));
      idle(1);
      checkOutput("d2_flush_next", obs[1], killed(e2));
      idle(4);

      checkCount("dut1_queue_drained", expq0.size(), 0);
      checkCount("dut2_queue_drained", expq1.size(), 0);
      checkCount("dut3_queue_drained", expq2.size(), 0);

`ifdef BFX_STALL_CNT_EN
      // Long stall saturates the counter; reset clears it.
      stim  = '0;
      stall = 1'b1;
      flush = 1'b0;
      repeat (70000) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) checkCount($sformatf("sat_cnt_dut%0d", k + 1), int'(cnt[k]), 32'hFFFF);
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) checkCount($sformatf("clr_cnt_dut%0d", k + 1), int'(cnt[k]), 0);
      rstn  = 1'b1;
      stall = 1'b0;
`endif

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
